// File: rtl/dual_lane_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dual_lane_pipe
// Brief    : Two independent lanes: input FIFO -> STAGES-deep +1 pipeline ->
//            valid/ready output, with registered early stall to the producer.
// Revision : 1.0
// ============================================================================
module dual_lane_pipe #(
  parameter int DEPTH  = 8,
  parameter int STAGES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pipeline1_inputs,
  input  logic [31:0] pipeline2_inputs,
  input  logic [1:0]  in_valid,
  input  logic        flush_1,
  input  logic        flush_2,
  output logic        stall_1,
  output logic        stall_2,
  output logic [31:0] out_data_1,
  output logic [31:0] out_data_2,
  output logic [1:0]  out_valid,
  input  logic [1:0]  out_ready,
  output logic [1:0]  overflow
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_full      = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_stall_lvl = c_cw'(DEPTH - 1);

  logic [31:0] w_in_data  [2];
  logic [31:0] w_out_data [2];
  logic [1:0]  w_flush;
  logic [1:0]  w_stall;

  assign w_in_data[0] = pipeline1_inputs;
  assign w_in_data[1] = pipeline2_inputs;
  assign w_flush      = {flush_2, flush_1};
  assign stall_1      = w_stall[0];
  assign stall_2      = w_stall[1];
  assign out_data_1   = w_out_data[0];
  assign out_data_2   = w_out_data[1];

  for (genvar L = 0; L < 2; L++) begin : g_lane
    logic [31:0]       r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_cw-1:0]   r_count;
    logic [c_cw-1:0]   w_count_next;
    logic [STAGES-1:0] r_v;
    logic [31:0]       r_d [STAGES];
    logic              r_stall;
    logic              r_overflow;
    logic              w_advance;
    logic              w_pop;
    logic              w_push_req;
    logic              w_push;
    logic              w_drop;
    logic              w_full;

    // A full FIFO still takes a word when the head leaves in the same cycle.
    always_comb begin
      w_full       = (r_count == c_full);
      w_advance    = ~r_v[STAGES-1] | out_ready[L];
      w_pop        = w_advance & (r_count != '0);
      w_push_req   = in_valid[L] & ~w_flush[L];
      w_push       = w_push_req & (~w_full | w_pop);
      w_drop       = w_push_req & w_full & ~w_pop;
      w_count_next = r_count + c_cw'(w_push) - c_cw'(w_pop);
    end

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_in_data[L];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_v        <= '0;
        r_stall    <= 1'b0;
        r_overflow <= 1'b0;
        for (int i = 0; i < STAGES; i++) r_d[i] <= '0;
      end else begin
        if (w_drop) r_overflow <= 1'b1;
        if (w_flush[L]) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
          r_v      <= '0;
          r_stall  <= 1'b0;
        end else begin
          if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
          if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
          r_count <= w_count_next;
          r_stall <= (w_count_next >= c_stall_lvl);
          // The whole pipeline moves or holds as one unit.
          if (w_advance) begin
            for (int i = STAGES - 1; i > 0; i--) begin
              r_v[i] <= r_v[i-1];
              r_d[i] <= r_d[i-1] + 32'd1;
            end
            r_v[0] <= w_pop;
            r_d[0] <= r_mem[r_rd_ptr] + 32'd1;
          end
        end
      end
    end

    assign w_out_data[L] = r_d[STAGES-1];
    assign out_valid[L]  = r_v[STAGES-1];
    assign overflow[L]   = r_overflow;
    assign w_stall[L]    = r_stall;
  end

endmodule
`default_nettype wire

// File: tb/tb_dual_lane_pipe.sv
`default_nettype none
// Testbench for dual_lane_pipe: directed scenarios and randomized traffic,
// scored against a queue model where each accepted word must emerge as word+STAGES.
module tb_dual_lane_pipe;
  localparam int DEPTH  = 8;
  localparam int STAGES = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pipeline1_inputs, pipeline2_inputs;
  logic [1:0]  in_valid, out_ready, out_valid, overflow;
  logic        flush_1, flush_2, stall_1, stall_2;
  logic [31:0] out_data_1, out_data_2;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];
  int          hs_cnt [2] = '{0, 0};
  logic [1:0]  held = 2'b00;
  logic [31:0] held_data [2];
  logic        mon_en = 1'b0;
  logic [1:0]  acc_mask = 2'b11;

  int          t0, lat, seen, base;
  logic [31:0] val;
  logic [1:0]  pst, cur, v, f, rdy;
  logic        s1, s2;

  dual_lane_pipe #(.DEPTH(DEPTH), .STAGES(STAGES)) dut (
    .clk(clk), .reset(reset),
    .pipeline1_inputs(pipeline1_inputs), .pipeline2_inputs(pipeline2_inputs),
    .in_valid(in_valid), .flush_1(flush_1), .flush_2(flush_2),
    .stall_1(stall_1), .stall_2(stall_2),
    .out_data_1(out_data_1), .out_data_2(out_data_2),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [31:0] x);
    return x + 32'(STAGES);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp_v);
    end
  endtask

  task automatic mon_lane(input int k, input logic vv, input logic rr, input logic [31:0] d);
    logic [31:0] e;
    logic        empty;
    if (vv && held[k]) check($sformatf("hold_stable_l%0d", k + 1), d, held_data[k]);
    if (vv && rr) begin
      hs_cnt[k]++;
      empty = (k == 0) ? (exp_q1.size() == 0) : (exp_q2.size() == 0);
      if (empty) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_l%0d actual=%h required=none", k + 1, d);
      end else begin
        if (k == 0) e = exp_q1.pop_front();
        else        e = exp_q2.pop_front();
        check($sformatf("data_l%0d", k + 1), d, e);
      end
    end
    held[k]      = vv && !rr;
    held_data[k] = d;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_lane(0, out_valid[0], out_ready[0], out_data_1);
      mon_lane(1, out_valid[1], out_ready[1], out_data_2);
    end
  end

  // One clock of stimulus; the model is updated at the edge that samples it.
  task automatic step(input logic [1:0] sv, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] sf, input logic [1:0] sr);
    in_valid = sv; pipeline1_inputs = a; pipeline2_inputs = b;
    flush_1 = sf[0]; flush_2 = sf[1]; out_ready = sr;
    @(posedge clk);
    if (reset) begin
      exp_q1.delete();
      exp_q2.delete();
    end else begin
      if (sf[0]) exp_q1.delete();
      else if (sv[0] && acc_mask[0]) exp_q1.push_back(model(a));
      if (sf[1]) exp_q2.delete();
      else if (sv[1] && acc_mask[1]) exp_q2.push_back(model(b));
    end
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q1.size() != 0 || exp_q2.size() != 0) && n < 300) begin
      step(2'b00, 0, 0, 2'b00, 2'b11);
      n++;
    end
    checks++;
    if (exp_q1.size() != 0 || exp_q2.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d/%0d required=0/0", exp_q1.size(), exp_q2.size());
    end
    check("idle_after_drain", 32'(out_valid), 32'd0);
  endtask

  task automatic wait_valid(input int k, input int ts, input logic [1:0] sr, output int l);
    int n = 0;
    while (!out_valid[k] && n < 50) begin
      step(2'b00, 0, 0, 2'b00, sr);
      n++;
    end
    l = out_valid[k] ? (cyc - ts) : -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 0; pipeline1_inputs = 0; pipeline2_inputs = 0;
    flush_1 = 0; flush_2 = 0; out_ready = 0;
    @(posedge clk); #1;
    step(2'b00, 0, 0, 2'b00, 2'b00);
    step(2'b00, 0, 0, 2'b00, 2'b00);
    reset = 1'b0;
    check("rst_stall", 32'({stall_2, stall_1}), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data_1", out_data_1, 32'd0);
    check("rst_out_data_2", out_data_2, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    mon_en = 1'b1;

    // Single word on lane 1
    t0 = cyc;
    step(2'b01, 32'h10, 0, 2'b00, 2'b11);
    wait_valid(0, t0, 2'b11, lat);
    check("single_latency", 32'(lat), 32'(STAGES + 1));
    check("single_data", out_data_1, 32'h13);
    check("single_lane2_idle", 32'(out_valid[1]), 32'd0);
    drain();

    // Arithmetic wrap
    step(2'b01, 32'hFFFF_FFFF, 0, 2'b00, 2'b11);
    wait_valid(0, cyc, 2'b11, lat);
    check("wrap_data", out_data_1, 32'h0000_0002);
    drain();

    // Sustained backpressure, producer reacting to stall one cycle late
    pst = 0; seen = -1; val = 0;
    for (int i = 0; i < 60; i++) begin
      cur = {stall_2, stall_1};
      if (cur[0] && seen < 0) seen = i;
      v = {1'b0, !pst[0]};
      pst = cur;
      step(v, val, 0, 2'b00, (i < 30) ? 2'b10 : 2'b11);
      if (v[0]) val = val + 32'd2;
    end
    check("bp_stall_rise_cycle", 32'(seen), 32'(DEPTH + STAGES - 1));
    check("bp_overflow", 32'(overflow), 32'd0);
    drain();

    // Flush of lane 2 with a valid input in the same cycle
    for (int i = 0; i < 5; i++) step(2'b10, 0, 32'h100 + 32'(i), 2'b00, 2'b01);
    check("flush_pre_valid", 32'(out_valid[1]), 32'd1);
    step(2'b10, 0, 32'hDEAD, 2'b10, 2'b01);
    check("flush_valid_cleared", 32'(out_valid[1]), 32'd0);
    check("flush_stall_cleared", 32'(stall_2), 32'd0);
    t0 = cyc;
    step(2'b10, 0, 32'h200, 2'b00, 2'b11);
    wait_valid(1, t0, 2'b11, lat);
    check("flush_empty_latency", 32'(lat), 32'(STAGES + 1));
    check("flush_next_data", out_data_2, 32'h203);
    drain();

    // Lane independence: lane 1 blocked, lane 2 free
    pst = 0; s1 = 0; s2 = 0; base = hs_cnt[1];
    for (int i = 0; i < 20 + STAGES + 1; i++) begin
      cur = {stall_2, stall_1};
      s1 |= cur[0];
      s2 |= cur[1];
      v = (i < 20) ? ~pst : 2'b00;
      pst = cur;
      step(v, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 2'b00, 2'b10);
    end
    check("indep_lane2_rate", 32'(hs_cnt[1] - base), 32'd20);
    check("indep_stall_1", 32'(s1), 32'd1);
    check("indep_stall_2", 32'(s2), 32'd0);
    drain();

    // Randomized traffic with flushes and random backpressure
    pst = 0;
    for (int i = 0; i < 400; i++) begin
      cur = {stall_2, stall_1};
      v[0] = !pst[0] && ($urandom_range(0, 3) != 0);
      v[1] = !pst[1] && ($urandom_range(0, 3) != 0);
      f[0] = ($urandom_range(0, 39) == 0);
      f[1] = ($urandom_range(0, 39) == 0);
      rdy[0] = ($urandom_range(0, 2) != 0);
      rdy[1] = ($urandom_range(0, 2) != 0);
      pst = cur;
      step(v, $urandom, $urandom, f, rdy);
    end
    check("rand_overflow", 32'(overflow), 32'd0);
    drain();

    // Forced overflow on lane 1: capacity is DEPTH FIFO words + STAGES in the pipe
    for (int i = 0; i < DEPTH + STAGES + 3; i++) begin
      if (i == DEPTH + STAGES) check("ovf_before_drop", 32'(overflow), 32'd0);
      acc_mask = {1'b1, (i < DEPTH + STAGES)};
      step(2'b01, 32'h3000 + 32'(i), 0, 2'b00, 2'b00);
    end
    acc_mask = 2'b11;
    check("ovf_after_drop", 32'(overflow), 32'd1);
    step(2'b00, 0, 0, 2'b01, 2'b00);
    check("ovf_sticky_flush", 32'(overflow), 32'd1);
    check("ovf_flush_valid", 32'(out_valid[0]), 32'd0);
    drain();

    // Reset mid-operation with both lanes loaded
    pst = 0;
    for (int i = 0; i < 14; i++) begin
      cur = {stall_2, stall_1};
      v = ~pst;
      pst = cur;
      step(v, 32'h4000 + 32'(i), 32'h5000 + 32'(i), 2'b00, 2'b00);
    end
    check("mid_pre_valid", 32'(out_valid), 32'd3);
    reset = 1'b1;
    step(2'b11, 32'h6000, 32'h6001, 2'b00, 2'b00);
    reset = 1'b0;
    check("mid_rst_stall", 32'({stall_2, stall_1}), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data_1", out_data_1, 32'd0);
    check("mid_rst_data_2", out_data_2, 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    t0 = cyc;
    step(2'b01, 32'h77, 0, 2'b00, 2'b11);
    wait_valid(0, t0, 2'b11, lat);
    check("mid_rst_latency", 32'(lat), 32'(STAGES + 1));
    check("mid_rst_data", out_data_1, 32'h7A);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
